// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling mid-bit at T = FREQ/BAUDRATE clocks per bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int BAUDRATE = 115200,
  parameter int FREQ     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  localparam int T = FREQ / BAUDRATE;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t      r_state, w_next;
  logic        r_rx_m, r_rx_s, r_rx_d;
  logic [31:0] r_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_rdata;
  logic        r_rvalid, r_frame_err;
  logic        w_mid, w_end, w_stop_done;
  assign w_mid       = r_cnt == 32'(T / 2 - 1);
  assign w_end       = r_cnt == 32'(T - 1);
  assign w_stop_done = r_state == STOP && w_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_rx_m, r_rx_s, r_rx_d} <= 3'b111;
    else {r_rx_m, r_rx_s, r_rx_d} <= {rx, r_rx_m, r_rx_s};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = (r_rx_d && !r_rx_s) ? START : IDLE;
      START:  w_next = w_mid ? (r_rx_s ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   w_next = (w_end && r_bit_cnt == 4'd7) ? PARITY : DATA;
      PARITY: w_next = w_end ? STOP : PARITY;
`else
      DATA:   w_next = (w_end && r_bit_cnt == 4'd7) ? STOP : DATA;
`endif
      STOP:   w_next = w_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt    <= (r_state == IDLE || r_state != w_next || w_end) ? '0 : r_cnt + 32'd1;
      r_rvalid <= w_stop_done;
      if (r_state == IDLE) r_bit_cnt <= '0;
      else if (r_state == DATA && w_end) r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_state == DATA && w_end) r_shift <= {r_rx_s, r_shift[7:1]};
      if (w_stop_done) begin
        r_rdata     <= r_shift;
        r_frame_err <= ~r_rx_s;
      end
    end
`ifdef UART_RX_PARITY_EN
  logic r_par, r_parity_err;
  // Even parity: the eight data bits plus the parity bit must hold an even number of ones.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == PARITY && w_end) r_par <= r_rx_s;
      if (w_stop_done) r_parity_err <= ^{r_shift, r_par};
    end
`endif
  always_comb begin
    busy      = r_state != IDLE;
    rdata     = r_rdata;
    rvalid    = r_rvalid;
    frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    parity_err = r_parity_err;
`endif
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at T=16 clocks/bit; a queue of expected bytes is checked on every rvalid.
module tb_uart_rx;
  localparam int T = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
  localparam int N_FRAMES = 8;
`else
  localparam int LAT = 155;
  localparam int N_FRAMES = 6;
`endif
  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] rdata;
  logic       rvalid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif
  typedef struct {logic [7:0] d; logic fe; logic pe;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_tests = 0, n_fail = 0, cyc = 0, rv_cnt = 0, t_start = 0, rv0 = 0;
  bit   chk_lat = 1'b0;
  logic prev_rv = 1'b0;

  uart_rx #(.BAUDRATE(1), .FREQ(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rdata(rdata), .rvalid(rvalid), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic pbit, input int gap);
    exp_t x;
    x.d = d; x.fe = ~stop; x.pe = ^d ^ pbit;
    sb.push_back(x);
    t_start = cyc;
    rx = 1'b0; tick(T);
    for (int i = 0; i < 8; i++) begin rx = d[i]; tick(T); end
`ifdef UART_RX_PARITY_EN
    rx = pbit; tick(T);
`endif
    rx = stop; tick(T);
    rx = 1'b1; tick(gap);
  endtask

  always @(negedge clk) begin
    if (prev_rv) check("rvalid_width", rvalid, 0);
    if (!rst && rvalid) begin
      rv_cnt++;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL unexpected_rvalid: got rdata %0h expected no frame", rdata);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.d);
        check("frame_err", frame_err, e.fe);
`ifdef UART_RX_PARITY_EN
        check("parity_err", parity_err, e.pe);
`endif
        if (chk_lat) begin
          check("latency", cyc - t_start, LAT);
          chk_lat = 1'b0;
        end
      end
    end
    prev_rv = rvalid;
  end

  initial begin
    tick(3);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_parity_err", parity_err, 0);
`endif
    rst = 1'b0;
    tick(5);
    chk_lat = 1'b1;
    send(8'hA5, 1'b1, ^8'hA5, 20);
    check("a5_pulses", rv_cnt, 1);
    send(8'h3C, 1'b0, ^8'h3C, 20);
    check("3c_frame_err_held", frame_err, 1);
    send(8'h01, 1'b1, ^8'h01, 20);
    check("fe_cleared", frame_err, 0);
    rv0 = rv_cnt;
    rx = 1'b0; tick(4);
    check("glitch_busy_high", busy, 1);
    rx = 1'b1; tick(7);
    check("glitch_busy_low", busy, 0);
    tick(20);
    check("glitch_no_rvalid", rv_cnt, rv0);
    send(8'h55, 1'b1, ^8'h55, 0);
    send(8'hAA, 1'b1, ^8'hAA, 20);
    check("b2b_last", rdata, 8'hAA);
    rv0 = rv_cnt;
    rx = 1'b0; tick(T);
    rx = 1'b1; tick(T * 4 + 8);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_rdata", rdata, 0);
    tick(3);
    rst = 1'b0;
    tick(T * 8);
    check("abort_no_rvalid", rv_cnt, rv0);
    check("abort_rdata_held", rdata, 0);
    send(8'h12, 1'b1, ^8'h12, 20);
    check("post_rst_rdata", rdata, 8'h12);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 20);
    check("par_bad", parity_err, 1);
    send(8'h07, 1'b1, 1'b1, 20);
    check("par_good", parity_err, 0);
`endif
    check("sb_empty", sb.size(), 0);
    check("frame_count", rv_cnt, N_FRAMES);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 115200, serial bit rate in bit/s.
REQ-002 SHALL have parameter FREQ, default 50_000_000, clk frequency in Hz; T = FREQ / BAUDRATE (integer division) clocks per bit.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rdata  output  8  last received byte.
REQ-007 SHALL have port rvalid  output  1  one-cycle pulse, rdata/frame_err updated.
REQ-008 SHALL have port frame_err  output  1  stop bit of the last frame sampled low.
REQ-009 SHALL have port busy  output  1  high while a frame is being received (state != IDLE).

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s and its 1-cycle delayed copy rx_d.
REQ-011 SHALL implement states IDLE, START, DATA, STOP (plus PARITY under REQ-026); encoding is free.
REQ-012 IDLE: on rx_d==1 && rx_s==0 (falling edge) SHALL go to START with cnt_clk=0, bit counter=0.
REQ-013 cnt_clk SHALL count clk cycles within the current bit; it is cleared on every state transition and on every bit advance.
REQ-014 START: at cnt_clk==T/2-1, SHALL sample rx_s; 0 -> DATA with cnt_clk=0; 1 -> IDLE (glitch rejected, no rvalid).
REQ-015 DATA: at cnt_clk==T-1 (mid-bit, since START ends at the mid-point), SHALL shift rx_s in LSB first; after the 8th sample SHALL go to STOP (or PARITY).
REQ-016 STOP: at cnt_clk==T-1, SHALL sample rx_s, load rdata with the assembled byte, set frame_err = ~rx_s, pulse rvalid for exactly one cycle (the next cycle), and go to IDLE.
REQ-017 SHALL return to IDLE at mid-stop-bit so that a start bit immediately following the stop bit is detected.
REQ-018 rvalid SHALL pulse on every completed frame, including frames with frame_err=1.
REQ-019 rdata and frame_err SHALL hold their values until the next rvalid; there is no backpressure, and a new frame overwrites them.
REQ-020 Falling edges of rx_s outside IDLE SHALL be ignored.
REQ-021 cnt_clk SHALL be 32 bits wide; the bit counter SHALL be 4 bits wide.

Reset
REQ-022 On rst high, SHALL immediately force: state=IDLE, cnt_clk=0, bit counter=0, shift register=0, synchronizer flops=1.
REQ-023 Output reset values SHALL be rdata=8'h00, rvalid=0, frame_err=0, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rvalid.
REQ-025 After rst deasserts, a frame SHALL be accepted only after a fresh 1->0 transition of rx_s.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined: SHALL add state PARITY between DATA and STOP (sampled at cnt_clk==T-1), expect even parity over the 8 data bits, and add port parity_err  output  1, reset 0, updated with rvalid and held like frame_err.
REQ-027 Without UART_RX_PARITY_EN: SHALL have no PARITY state and no parity_err port; the frame is 1 start + 8 data + 1 stop.

Verification (FREQ=16, BAUDRATE=1, T=16 unless stated)
REQ-028 Send 8'hA5 with a valid stop bit -> exactly one rvalid pulse, rdata=8'hA5, frame_err=0, rvalid 1 cycle after the mid-stop sample.
REQ-029 Send 8'h3C with the stop bit driven low -> rvalid pulses, rdata=8'h3C, frame_err=1; then send 8'h01 valid -> frame_err returns to 0.
REQ-030 Drive a 4-cycle low glitch on idle rx -> no rvalid, busy returns to 0 within T/2+3 cycles.
REQ-031 Send 8'h55 and 8'hAA back-to-back with a single stop bit, no idle gap -> two rvalid pulses with rdata 8'h55 then 8'hAA.
REQ-032 Assert rst during data bit 4 of 8'hFF -> busy=0 and rvalid=0 immediately; rdata stays 8'h00; the next valid frame 8'h12 is received correctly.
REQ-033 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> parity_err=1; send it with parity bit 1 -> parity_err=0.
